// File: rtl/alu_pkg.sv
// Shared constants for the 32-bit ALU: datapath width and opcode encodings.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [OP_W-1:0] OP_ADD = 5'b00000;
    localparam logic [OP_W-1:0] OP_SUB = 5'b00001;
    localparam logic [OP_W-1:0] OP_AND = 5'b00010;
    localparam logic [OP_W-1:0] OP_OR  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SLL = 5'b00100;
    localparam logic [OP_W-1:0] OP_SRA = 5'b00101;

endpackage

// File: rtl/alu_adder.sv
// Plain 32-bit adder with carry-in; subtraction is formed by the caller as a + ~b + 1.
module alu_adder
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum
);

    // Carry-out is intentionally dropped: arithmetic wraps modulo 2^32.
    assign sum = a + b + DATA_W'(cin);

endmodule

// File: rtl/alu.sv
// 32-bit ALU with registered result and compare flags.
// Shifts (SLL/SRA) are built only when ALU_SHIFT_EN is defined.
module alu
    import alu_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [DATA_W-1:0]  data_operandA,
    input  logic [DATA_W-1:0]  data_operandB,
    input  logic [OP_W-1:0]    ctrl_ALUopcode,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic [DATA_W-1:0]  data_result,
    output logic               isNotEqual,
    output logic               isLessThan,
    output logic               overflow
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              add_ov;
    logic              sub_ov;
    logic [DATA_W-1:0] result_nxt;
    logic              ov_nxt;

    alu_adder u_add (
        .a   (data_operandA),
        .b   (data_operandB),
        .cin (1'b0),
        .sum (sum)
    );

    // The difference always runs so the compare flags are valid for every opcode.
    alu_adder u_sub (
        .a   (data_operandA),
        .b   (~data_operandB),
        .cin (1'b1),
        .sum (diff)
    );

    assign add_ov = (data_operandA[DATA_W-1] == data_operandB[DATA_W-1]) &&
                    (sum[DATA_W-1] != data_operandA[DATA_W-1]);
    assign sub_ov = (data_operandA[DATA_W-1] != data_operandB[DATA_W-1]) &&
                    (diff[DATA_W-1] != data_operandA[DATA_W-1]);

`ifndef ALU_SHIFT_EN
    logic unused_shamt;
    assign unused_shamt = ^ctrl_shiftamt;
`endif

    always_comb begin
        result_nxt = '0;
        ov_nxt     = 1'b0;
        case (ctrl_ALUopcode)
            OP_ADD: begin
                result_nxt = sum;
                ov_nxt     = add_ov;
            end
            OP_SUB: begin
                result_nxt = diff;
                ov_nxt     = sub_ov;
            end
            OP_AND: result_nxt = data_operandA & data_operandB;
            OP_OR:  result_nxt = data_operandA | data_operandB;
`ifdef ALU_SHIFT_EN
            OP_SLL: result_nxt = data_operandA << ctrl_shiftamt;
            OP_SRA: result_nxt = DATA_W'($signed(data_operandA) >>> ctrl_shiftamt);
`endif
            default: begin
                result_nxt = '0;
                ov_nxt     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_result <= '0;
            isNotEqual  <= 1'b0;
            isLessThan  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            data_result <= result_nxt;
            isNotEqual  <= |diff;
            isLessThan  <= diff[DATA_W-1] ^ sub_ov;
            overflow    <= ov_nxt;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the 32-bit ALU; shift expectations follow ALU_SHIFT_EN.
module tb_alu;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [4:0]  ctrl_ALUopcode;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] data_result;
    logic        isNotEqual;
    logic        isLessThan;
    logic        overflow;

    int n_tests;
    int n_fail;

    alu dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_ALUopcode (ctrl_ALUopcode),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .data_result    (data_result),
        .isNotEqual     (isNotEqual),
        .isLessThan     (isLessThan),
        .overflow       (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] res,
                             input logic ne, input logic lt, input logic ov);
        check({tag, ".result"}, data_result, res);
        check({tag, ".ne"}, 32'(isNotEqual), 32'(ne));
        check({tag, ".lt"}, 32'(isLessThan), 32'(lt));
        check({tag, ".ov"}, 32'(overflow), 32'(ov));
    endtask

    // Drive one op, clock it in, sample 1 time unit after the edge.
    task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input logic [31:0] res,
                       input logic ne, input logic lt, input logic ov);
        ctrl_ALUopcode = op;
        data_operandA  = a;
        data_operandB  = b;
        ctrl_shiftamt  = sh;
        @(posedge clock);
        #1;
        check_all(tag, res, ne, lt, ov);
    endtask

    logic [31:0] exp_sll;
    logic [31:0] exp_sra;
    logic [31:0] exp_sra0;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset          = 1'b1;
        ctrl_ALUopcode = 5'b00000;
        data_operandA  = 32'd10;
        data_operandB  = 32'd5;
        ctrl_shiftamt  = 5'd0;
        @(posedge clock);
        #1;
        check_all("reset0", 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        run("add1", 5'b00000, 32'd10, 32'd5, 5'd0, 32'd15, 1'b1, 1'b0, 1'b0);
        run("add2", 5'b00000, 32'hFFFF_FFF1, 32'd7, 5'd0, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0);
        run("add3", 5'b00000, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
        run("add4", 5'b00000, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0);

        run("sub1", 5'b00001, 32'd10, 32'd5, 5'd0, 32'd5, 1'b1, 1'b0, 1'b0);
        run("sub2", 5'b00001, 32'd5, 32'd10, 5'd0, 32'hFFFF_FFFB, 1'b1, 1'b1, 1'b0);
        run("sub3", 5'b00001, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
        run("sub4", 5'b00001, 32'd7, 32'd7, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        run("sub5", 5'b00001, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h8000_0000, 1'b1, 1'b0, 1'b1);

        run("and1", 5'b00010, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0);
        run("and2", 5'b00010, 32'hFFFF_FFFF, 32'h1234_5678, 5'd0, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
        run("and3", 5'b00010, 32'h0, 32'hABCD_1234, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        run("or1",  5'b00011, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);

`ifdef ALU_SHIFT_EN
        exp_sll  = 32'h8000_0000;
        exp_sra  = 32'hF800_0000;
        exp_sra0 = 32'h8000_0000;
`else
        exp_sll  = 32'h0;
        exp_sra  = 32'h0;
        exp_sra0 = 32'h0;
`endif
        run("sll31", 5'b00100, 32'd1, 32'd1, 5'd31, exp_sll, 1'b0, 1'b0, 1'b0);
        run("sra4",  5'b00101, 32'h8000_0000, 32'h8000_0000, 5'd4, exp_sra, 1'b0, 1'b0, 1'b0);
        run("sra0",  5'b00101, 32'h8000_0000, 32'h8000_0000, 5'd0, exp_sra0, 1'b0, 1'b0, 1'b0);
`ifdef ALU_SHIFT_EN
        run("sll0",  5'b00100, 32'h1234_5678, 32'h1234_5678, 5'd0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        run("sra_pos", 5'b00101, 32'h4000_0000, 32'h4000_0000, 5'd2, 32'h1000_0000, 1'b0, 1'b0, 1'b0);
`endif

        run("unl1", 5'b11111, 32'd3, 32'd3, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        run("unl2", 5'b00110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset while an ADD result is held: outputs clear, then the next op lands one edge later.
        run("pre_rst", 5'b00000, 32'd10, 32'd5, 5'd0, 32'd15, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_all("in_rst", 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        run("post_rst", 5'b00001, 32'd5, 32'd10, 5'd0, 32'hFFFF_FFFB, 1'b1, 1'b1, 1'b0);

        // Output must hold through the cycle until the next edge.
        @(negedge clock);
        check("hold.result", data_result, 32'hFFFF_FFFB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Module SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-004 data_operandA  input  32  operand A, two's-complement.
REQ-005 data_operandB  input  32  operand B, two's-complement.
REQ-006 ctrl_ALUopcode  input  5  operation select.
REQ-007 ctrl_shiftamt  input  5  shift amount 0..31.
REQ-008 data_result  output  32  registered operation result.
REQ-009 isNotEqual  output  1  registered, A != B.
REQ-010 isLessThan  output  1  registered, A < B signed.
REQ-011 overflow  output  1  registered, signed overflow of ADD/SUB.

Function
REQ-012 Opcodes SHALL be: 00000 ADD A+B; 00001 SUB A-B; 00010 AND A&B; 00011 OR A|B; 00100 SLL A<<shamt; 00101 SRA A>>>shamt (sign-filled).
REQ-013 Unlisted opcodes (00110..11111) SHALL produce data_result=0 and overflow=0.
REQ-014 Outputs SHALL be registered: values computed from inputs sampled at rising edge N appear after edge N and hold until edge N+1 (latency 1 cycle, throughput 1 op/cycle, no handshake).
REQ-015 ADD/SUB SHALL wrap modulo 2^32; carry-out is discarded.
REQ-016 overflow SHALL be 1 for ADD when A and B have equal sign and result sign differs; for SUB when A and B differ in sign and result sign differs from A; 0 for all other opcodes.
REQ-017 isNotEqual and isLessThan SHALL be computed from A-B on every cycle, regardless of opcode.
REQ-018 isLessThan SHALL equal diff[31] XOR sub_overflow, so it is correct even when A-B overflows (e.g. A=0x80000000, B=1 gives 1).
REQ-019 isNotEqual SHALL be 1 iff any bit of A-B is nonzero.
REQ-020 Shift amount 0 SHALL return A unchanged; SRA of a negative A SHALL fill with 1s.

Reset
REQ-021 While reset is high at a rising edge, data_result, isNotEqual, isLessThan and overflow SHALL all be 0 after that edge, overriding any operation.
REQ-022 Operation sampled in the cycle reset is asserted SHALL be discarded; the first valid result appears one edge after the first edge with reset low.
REQ-023 No state other than the output registers SHALL exist.

Configuration
REQ-024 Macro ALU_SHIFT_EN defined: SLL and SRA are implemented per REQ-012.
REQ-025 ALU_SHIFT_EN undefined: shifter logic is omitted; opcodes 00100 and 00101 behave as unlisted opcodes (result 0); ctrl_shiftamt is ignored.

Structure
REQ-026 Package alu_pkg SHALL hold the 5-bit opcode constants (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRA) and the 32-bit data width constant.
REQ-027 Addition/subtraction SHALL be done in one sub-module alu_adder (32-bit adder with carry-in; SUB = A + ~B + 1), shared by ADD, SUB and the comparison outputs.
REQ-028 Shifter, logic ops and the result mux SHALL be inside alu; the output register is the only sequential logic.

Verification
REQ-029 ADD: A=10, B=5, then A=-15, B=7, then A=0x7FFFFFFF, B=1 -> result 15 ov=0; -8 ov=0; 0x80000000 ov=1, each one cycle later.
REQ-030 SUB: A=10, B=5 -> 5, ne=1, lt=0; A=5, B=10 -> -5, ne=1, lt=1; A=0x80000000, B=1 -> 0x7FFFFFFF, ov=1, lt=1; A=B=7 -> 0, ne=0, lt=0.
REQ-031 AND/OR: 0xF0F0F0F0 & 0x0F0F0F0F -> 0; 0xFFFFFFFF & 0x12345678 -> 0x12345678; 0 & 0xABCD1234 -> 0; 0xF0F0F0F0 | 0x0F0F0F0F -> 0xFFFFFFFF; ov=0 for all.
REQ-032 Shifts (ALU_SHIFT_EN): SLL A=1, shamt=31 -> 0x80000000; SRA A=0x80000000, shamt=4 -> 0xF8000000; shamt=0 -> A; without the macro both give 0.
REQ-033 Reset: ADD with result 15 in flight, assert reset for one edge -> all outputs 0 after that edge; deassert -> next op result appears one edge later.
REQ-034 Unlisted opcode 11111 with A=3, B=3 -> result 0, ov=0, ne=0, lt=0.
